// File: rtl/axi_lite_reg_pkg.sv
// Shared types, response codes and register-mode decode for the AXI4-Lite register bank.
package axi_lite_reg_pkg;

    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam int unsigned MAX_REGS    = 64;

    typedef enum logic [1:0] {
        REG_RW,
        REG_RO,
        REG_W1C
    } reg_mode_e;

    typedef enum logic {
        W_IDLE,
        W_RESP
    } wr_state_e;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_e;

    // RO wins over W1C when both mask bits are set
    function automatic reg_mode_e reg_mode(input int unsigned i,
                                           input logic [MAX_REGS-1:0] ro_mask,
                                           input logic [MAX_REGS-1:0] w1c_mask);
        reg_mode_e m;
        m = REG_RW;
        if (w1c_mask[6'(i)]) m = REG_W1C;
        if (ro_mask[6'(i)])  m = REG_RO;
        return m;
    endfunction

endpackage

// File: rtl/axi_lite_reg_cell.sv
// One register of the bank: storage, byte-strobe merge and sticky-status behaviour.
module axi_lite_reg_cell
    import axi_lite_reg_pkg::*;
#(
    parameter reg_mode_e     MODE    = REG_RW,
    parameter int unsigned   DW      = 32,
    parameter logic [DW-1:0] RST_VAL = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_wr_en,
    input  logic [DW-1:0]   i_wdata,
    input  logic [DW/8-1:0] i_wstrb,
    input  logic [DW-1:0]   i_sts_set,
    output logic [DW-1:0]   o_value
);

    localparam int unsigned SW = DW / 8;

    logic [DW-1:0] w_bmask;

    // Expand byte strobes into a per-bit write mask
    always_comb begin
        w_bmask = '0;
        for (int b = 0; b < SW; b++) begin
            w_bmask[b*8 +: 8] = {8{i_wstrb[b]}};
        end
    end

    generate
        if (MODE == REG_RO) begin : g_ro
            logic w_unused;
            assign w_unused = ^{clk, rst, i_wr_en, i_wdata, w_bmask, i_sts_set};
            assign o_value  = '0;
        end else if (MODE == REG_W1C) begin : g_w1c
            logic [DW-1:0] r_q;
            // Sticky status: a set pulse on the same edge as a software clear wins
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_q <= '0;
                end else begin
                    r_q <= (r_q & ~(i_wr_en ? (i_wdata & w_bmask) : '0)) | i_sts_set;
                end
            end
            assign o_value = r_q;
        end else begin : g_rw
            logic [DW-1:0] r_q;
            logic          w_unused;
            assign w_unused = ^i_sts_set;
            // Plain read/write storage, updated only on strobed bytes
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_q <= RST_VAL;
                end else if (i_wr_en) begin
                    r_q <= (r_q & ~w_bmask) | (i_wdata & w_bmask);
                end
            end
            assign o_value = r_q;
        end
    endgenerate

endmodule

// File: rtl/axi_lite_reg_bank.sv
// AXI4-Lite slave register bank: write/read channel FSMs, address decode and read mux.
module axi_lite_reg_bank
    import axi_lite_reg_pkg::*;
#(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 6,
    parameter int unsigned NUM_REGS           = 16,
    parameter logic [NUM_REGS-1:0] RO_MASK    = '0,
    parameter logic [NUM_REGS-1:0] W1C_MASK   = '0,
    parameter logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                                   S_AXI_ACLK,
    input  logic                                   S_AXI_ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
    input  logic [2:0]                             S_AXI_AWPROT,
    input  logic                                   S_AXI_AWVALID,
    output logic                                   S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
    input  logic                                   S_AXI_WVALID,
    output logic                                   S_AXI_WREADY,
    output logic [1:0]                             S_AXI_BRESP,
    output logic                                   S_AXI_BVALID,
    input  logic                                   S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
    input  logic [2:0]                             S_AXI_ARPROT,
    input  logic                                   S_AXI_ARVALID,
    output logic                                   S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
    output logic [1:0]                             S_AXI_RRESP,
    output logic                                   S_AXI_RVALID,
    input  logic                                   S_AXI_RREADY,
    output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_out,
    input  logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_in,
    input  logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] sts_set,
    output logic [NUM_REGS-1:0]                    wr_pulse
);

    localparam int unsigned DW       = C_S_AXI_DATA_WIDTH;
    localparam int unsigned AW       = C_S_AXI_ADDR_WIDTH;
    localparam int unsigned SW       = DW / 8;
    localparam int unsigned ADDR_LSB = $clog2(SW);
    localparam int unsigned IDXW     = AW - ADDR_LSB;

    // Write channel state
    wr_state_e          r_wstate;
    wr_state_e          w_wstate_nxt;
    logic               r_aw_held;
    logic               r_w_held;
    logic [IDXW-1:0]    r_awidx;
    logic [DW-1:0]      r_wdata;
    logic [SW-1:0]      r_wstrb;
    logic               r_awready;
    logic               r_wready;
    logic [1:0]         r_bresp;
    logic [NUM_REGS-1:0] r_wr_pulse;
    logic               w_aw_hs;
    logic               w_w_hs;
    logic               w_commit;
    logic               w_aw_held_nxt;
    logic               w_w_held_nxt;
    logic               w_awready_nxt;
    logic               w_wready_nxt;
    logic [NUM_REGS-1:0] w_wr_sel;
    logic               w_wr_inrange;

    // Read channel state
    rd_state_e          r_rstate;
    rd_state_e          w_rstate_nxt;
    logic               r_arready;
    logic [DW-1:0]      r_rdata;
    logic [1:0]         r_rresp;
    logic               w_ar_hs;
    logic               w_arready_nxt;
    logic [IDXW-1:0]    w_aridx;
    logic [NUM_REGS-1:0] w_rd_sel;
    logic               w_rd_hit;
    logic [DW-1:0]      w_rd_word;

    logic [DW-1:0]      w_cell_q [NUM_REGS];
    logic [DW-1:0]      w_rd_src [NUM_REGS];
    logic               w_unused;

    assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR, reg_in};

    assign w_aw_hs      = S_AXI_AWVALID & r_awready;
    assign w_w_hs       = S_AXI_WVALID & r_wready;
    assign w_wr_inrange = |w_wr_sel;
    assign w_aridx      = S_AXI_ARADDR[AW-1:ADDR_LSB];
    assign w_ar_hs      = S_AXI_ARVALID & r_arready;
    assign w_rd_hit     = |w_rd_sel;

    // Per-register decode, storage cells and read sources
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        localparam reg_mode_e MODE = reg_mode(i, 64'(RO_MASK), 64'(W1C_MASK));

        assign w_wr_sel[i] = (r_awidx == IDXW'(i));
        assign w_rd_sel[i] = (w_aridx == IDXW'(i));

        axi_lite_reg_cell #(
            .MODE    (MODE),
            .DW      (DW),
            .RST_VAL (RESET_VALUE[i*DW +: DW])
        ) u_cell (
            .clk       (S_AXI_ACLK),
            .rst       (S_AXI_ARESET),
            .i_wr_en   (w_commit & w_wr_sel[i]),
            .i_wdata   (r_wdata),
            .i_wstrb   (r_wstrb),
            .i_sts_set (sts_set[i*DW +: DW]),
            .o_value   (w_cell_q[i])
        );

        assign w_rd_src[i]          = (MODE == REG_RO) ? reg_in[i*DW +: DW] : w_cell_q[i];
        assign reg_out[i*DW +: DW]  = w_cell_q[i];
    end

    // Write FSM state register
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) r_wstate <= W_IDLE;
        else              r_wstate <= w_wstate_nxt;
    end

    // Write FSM next state: respond once both AW and W are held
    always_comb begin
        w_wstate_nxt = r_wstate;
        case (r_wstate)
            W_IDLE:  if (r_aw_held && r_w_held) w_wstate_nxt = W_RESP;
            W_RESP:  if (S_AXI_BREADY)          w_wstate_nxt = W_IDLE;
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    // Write FSM outputs: commit strobe, held flags and next-cycle ready levels
    always_comb begin
        w_commit      = 1'b0;
        w_aw_held_nxt = r_aw_held | w_aw_hs;
        w_w_held_nxt  = r_w_held | w_w_hs;
        case (r_wstate)
            W_IDLE: begin
                if (r_aw_held && r_w_held) begin
                    w_commit      = 1'b1;
                    w_aw_held_nxt = 1'b0;
                    w_w_held_nxt  = 1'b0;
                end
            end
            default: ;
        endcase
        w_awready_nxt = !w_aw_held_nxt && (w_wstate_nxt != W_RESP);
        w_wready_nxt  = !w_w_held_nxt && (w_wstate_nxt != W_RESP);
    end

    // Write channel capture, response and pulse registers
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            r_aw_held  <= 1'b0;
            r_w_held   <= 1'b0;
            r_awidx    <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_awready  <= 1'b0;
            r_wready   <= 1'b0;
            r_bresp    <= RESP_OKAY;
            r_wr_pulse <= '0;
        end else begin
            r_aw_held  <= w_aw_held_nxt;
            r_w_held   <= w_w_held_nxt;
            r_awready  <= w_awready_nxt;
            r_wready   <= w_wready_nxt;
            if (w_aw_hs) r_awidx <= S_AXI_AWADDR[AW-1:ADDR_LSB];
            if (w_w_hs) begin
                r_wdata <= S_AXI_WDATA;
                r_wstrb <= S_AXI_WSTRB;
            end
            if (w_commit) r_bresp <= w_wr_inrange ? RESP_OKAY : RESP_SLVERR;
            r_wr_pulse <= w_commit ? w_wr_sel : '0;
        end
    end

    // Read FSM state register
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) r_rstate <= R_IDLE;
        else              r_rstate <= w_rstate_nxt;
    end

    // Read FSM next state: one outstanding read, held until RREADY
    always_comb begin
        w_rstate_nxt = r_rstate;
        case (r_rstate)
            R_IDLE:  if (w_ar_hs)      w_rstate_nxt = R_DATA;
            R_DATA:  if (S_AXI_RREADY) w_rstate_nxt = R_IDLE;
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    // Read FSM output: address accepted only while no data is pending
    always_comb begin
        w_arready_nxt = (w_rstate_nxt == R_IDLE);
    end

    // Read mux over stored values and RO fabric inputs
    always_comb begin
        w_rd_word = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_rd_sel[i]) w_rd_word = w_rd_src[i];
        end
    end

    // Read data/response capture on AR handshake (pre-write values on a collision)
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            r_arready <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= RESP_OKAY;
        end else begin
            r_arready <= w_arready_nxt;
            if (w_ar_hs) begin
                r_rdata <= w_rd_hit ? w_rd_word : '0;
                r_rresp <= w_rd_hit ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    assign S_AXI_AWREADY = r_awready;
    assign S_AXI_WREADY  = r_wready;
    assign S_AXI_BVALID  = (r_wstate == W_RESP);
    assign S_AXI_BRESP   = r_bresp;
    assign S_AXI_ARREADY = r_arready;
    assign S_AXI_RVALID  = (r_rstate == R_DATA);
    assign S_AXI_RDATA   = r_rdata;
    assign S_AXI_RRESP   = r_rresp;
    assign wr_pulse      = r_wr_pulse;

endmodule
